// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with prescaled scan, tear-free
// frame-aligned display updates and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIV_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  en,
    output logic [6:0]  y,
    output logic        frame_done
);

    localparam logic [DIV_WIDTH-1:0] PRESC_MAX = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] PRESC_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] presc_r;
    logic [1:0]           idx_r;
    logic [15:0]          shadow_r;
    logic [15:0]          pending_r;
    logic                 pending_valid_r;
    logic [3:0]           en_r;
    logic [6:0]           y_r;
    logic                 frame_done_r;

    logic                 tick_s;
    logic                 wrap_s;
    logic [3:0]           nibble_s;
    logic                 blank_s;
    logic [3:0]           en_next_s;
    logic [6:0]           y_next_s;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            4'hF:    hex7 = 7'h0E;
            default: hex7 = 7'h7F;
        endcase
    endfunction

    assign tick_s = enable && (presc_r == PRESC_MAX);
    assign wrap_s = tick_s && (idx_r == 2'd3);

    // Select the current digit's nibble and decide whether it is a leading zero.
    always_comb begin
        nibble_s = 4'h0;
        blank_s  = 1'b0;
        case (idx_r)
            2'd0: begin
                nibble_s = shadow_r[3:0];
                blank_s  = 1'b0;
            end
            2'd1: begin
                nibble_s = shadow_r[7:4];
                blank_s  = blank_lz && (shadow_r[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s = shadow_r[11:8];
                blank_s  = blank_lz && (shadow_r[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s = shadow_r[15:12];
                blank_s  = blank_lz && (shadow_r[15:12] == 4'h0);
            end
            default: begin
                nibble_s = 4'h0;
                blank_s  = 1'b0;
            end
        endcase
    end

    // Next-cycle digit enable and segment pattern.
    always_comb begin
        en_next_s = 4'b1111;
        y_next_s  = 7'h7F;
        if (enable && !blank_s) begin
            en_next_s = ~(4'b0001 << idx_r);
            y_next_s  = hex7(nibble_s);
        end else begin
            en_next_s = 4'b1111;
            y_next_s  = 7'h7F;
        end
    end

    // Prescaler and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r <= {DIV_WIDTH{1'b0}};
            idx_r   <= 2'd0;
        end else if (enable) begin
            presc_r <= presc_r + PRESC_ONE;
            if (tick_s) begin
                idx_r <= idx_r + 2'd1;
            end else begin
                idx_r <= idx_r;
            end
        end else begin
            presc_r <= presc_r;
            idx_r   <= idx_r;
        end
    end

    // Shadow only changes at a frame boundary or while the display is dark.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_r        <= 16'h0000;
            pending_r       <= 16'h0000;
            pending_valid_r <= 1'b0;
        end else if (load && (wrap_s || !enable)) begin
            shadow_r        <= data_in;
            pending_r       <= data_in;
            pending_valid_r <= 1'b0;
        end else if (load) begin
            pending_r       <= data_in;
            pending_valid_r <= 1'b1;
        end else if (wrap_s && pending_valid_r) begin
            shadow_r        <= pending_r;
            pending_valid_r <= 1'b0;
        end else begin
            shadow_r        <= shadow_r;
            pending_r       <= pending_r;
            pending_valid_r <= pending_valid_r;
        end
    end

    // Registered display outputs and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            en_r         <= 4'b1111;
            y_r          <= 7'h7F;
            frame_done_r <= 1'b0;
        end else begin
            en_r         <= en_next_s;
            y_r          <= y_next_s;
            frame_done_r <= wrap_s;
        end
    end

    assign en         = en_r;
    assign y          = y_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with DIV_WIDTH=2
// (each digit lasts 4 enabled clocks, a frame 16).
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] data_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  en;
    logic [6:0]  y;
    logic        frame_done;

    int tests;
    int failed;

    seg7_scan_driver #(.DIV_WIDTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .en         (en),
        .y          (y),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ee, input logic [6:0] yy, input logic ff);
        tests++;
        assert (en === ee && y === yy && frame_done === ff)
        else begin
            failed++;
            $error("FAIL %s: got en=%b y=%h fd=%b, expected en=%b y=%h fd=%b",
                   tag, en, y, frame_done, ee, yy, ff);
        end
    endtask

    // Advance n clocks expecting a steady digit; frame_done expected on the last one if fd_last.
    task automatic digit(input string tag, input logic [3:0] ee, input logic [6:0] yy,
                         input int n, input logic fd_last);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk(tag, ee, yy, (fd_last && i == n - 1) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        reset    = 1'b0;
        enable   = 1'b1;
        load     = 1'b1;
        data_in  = 16'hFFFF;
        blank_lz = 1'b0;

        // Reset dominates enable and load
        digit("reset", 4'b1111, 7'h7F, 3, 1'b0);

        // Free-running scan of zero shadow, two frames
        reset = 1'b1;
        load  = 1'b0;
        for (int f = 0; f < 2; f++) begin
            digit("scan_d0", 4'b1110, 7'h40, 4, 1'b0);
            digit("scan_d1", 4'b1101, 7'h40, 4, 1'b0);
            digit("scan_d2", 4'b1011, 7'h40, 4, 1'b0);
            digit("scan_d3", 4'b0111, 7'h40, 4, 1'b1);
        end

        // Mid-frame load waits for the wrap
        digit("midload_d0", 4'b1110, 7'h40, 4, 1'b0);
        load    = 1'b1;
        data_in = 16'h12AF;
        digit("midload_d1", 4'b1101, 7'h40, 1, 1'b0);
        load    = 1'b0;
        data_in = 16'h0000;
        digit("midload_d1", 4'b1101, 7'h40, 3, 1'b0);
        digit("midload_d2", 4'b1011, 7'h40, 4, 1'b0);
        digit("midload_d3", 4'b0111, 7'h40, 4, 1'b1);
        digit("12AF_d0", 4'b1110, 7'h0E, 4, 1'b0);
        digit("12AF_d1", 4'b1101, 7'h08, 4, 1'b0);
        digit("12AF_d2", 4'b1011, 7'h24, 4, 1'b0);
        digit("12AF_d3", 4'b0111, 7'h79, 4, 1'b1);

        // Leading-zero blanking, shadow loaded while disabled
        blank_lz = 1'b1;
        enable   = 1'b0;
        load     = 1'b1;
        data_in  = 16'h0007;
        digit("off_load7", 4'b1111, 7'h7F, 1, 1'b0);
        load   = 1'b0;
        enable = 1'b1;
        digit("blz7_d0", 4'b1110, 7'h78, 4, 1'b0);
        digit("blz7_d1", 4'b1111, 7'h7F, 4, 1'b0);
        digit("blz7_d2", 4'b1111, 7'h7F, 4, 1'b0);
        digit("blz7_d3", 4'b1111, 7'h7F, 4, 1'b1);
        enable  = 1'b0;
        load    = 1'b1;
        data_in = 16'h0100;
        digit("off_load100", 4'b1111, 7'h7F, 1, 1'b0);
        load   = 1'b0;
        enable = 1'b1;
        digit("blz100_d0", 4'b1110, 7'h40, 4, 1'b0);
        digit("blz100_d1", 4'b1101, 7'h40, 4, 1'b0);
        digit("blz100_d2", 4'b1011, 7'h79, 4, 1'b0);
        digit("blz100_d3", 4'b1111, 7'h7F, 4, 1'b1);
        blank_lz = 1'b0;

        // Multiple loads in a frame, last one on the wrap edge
        digit("multi_d0", 4'b1110, 7'h40, 2, 1'b0);
        load    = 1'b1;
        data_in = 16'h1111;
        digit("multi_d0", 4'b1110, 7'h40, 1, 1'b0);
        load    = 1'b0;
        digit("multi_d0", 4'b1110, 7'h40, 1, 1'b0);
        digit("multi_d1", 4'b1101, 7'h40, 2, 1'b0);
        load    = 1'b1;
        data_in = 16'h2222;
        digit("multi_d1", 4'b1101, 7'h40, 1, 1'b0);
        load    = 1'b0;
        digit("multi_d1", 4'b1101, 7'h40, 1, 1'b0);
        digit("multi_d2", 4'b1011, 7'h79, 4, 1'b0);
        digit("multi_d3", 4'b0111, 7'h40, 3, 1'b0);
        load    = 1'b1;
        data_in = 16'h3333;
        digit("wrapload_d3", 4'b0111, 7'h40, 1, 1'b1);
        load    = 1'b0;
        data_in = 16'h0000;
        for (int f = 0; f < 2; f++) begin
            digit("3333_d0", 4'b1110, 7'h30, 4, 1'b0);
            digit("3333_d1", 4'b1101, 7'h30, 4, 1'b0);
            digit("3333_d2", 4'b1011, 7'h30, 4, 1'b0);
            digit("3333_d3", 4'b0111, 7'h30, 4, 1'b1);
        end

        // Pause during digit 2 and resume without skipping
        digit("pause_d0", 4'b1110, 7'h30, 4, 1'b0);
        digit("pause_d1", 4'b1101, 7'h30, 4, 1'b0);
        digit("pause_d2", 4'b1011, 7'h30, 2, 1'b0);
        enable = 1'b0;
        digit("paused", 4'b1111, 7'h7F, 3, 1'b0);
        enable = 1'b1;
        digit("resume_d2", 4'b1011, 7'h30, 2, 1'b0);
        digit("resume_d3", 4'b0111, 7'h30, 4, 1'b1);

        // Mid-frame reset drops a pending value
        digit("rst_d0", 4'b1110, 7'h30, 1, 1'b0);
        load    = 1'b1;
        data_in = 16'h5555;
        digit("rst_d0", 4'b1110, 7'h30, 1, 1'b0);
        load    = 1'b0;
        digit("rst_d0", 4'b1110, 7'h30, 1, 1'b0);
        reset = 1'b0;
        digit("midreset", 4'b1111, 7'h7F, 1, 1'b0);
        reset = 1'b1;
        for (int f = 0; f < 2; f++) begin
            digit("postrst_d0", 4'b1110, 7'h40, 4, 1'b0);
            digit("postrst_d1", 4'b1101, 7'h40, 4, 1'b0);
            digit("postrst_d2", 4'b1011, 7'h40, 4, 1'b0);
            digit("postrst_d3", 4'b0111, 7'h40, 4, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
